// File: rtl/jk_mod_counter_pkg.sv
// jk_mod_counter shared definitions.
// Direction encodings and terminal-count helper.
package jk_mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Value at which the counter wraps in the given direction.
    function automatic int term_value(input logic updown, input int modulus);
        return (updown == DIR_UP) ? modulus - 1 : 0;
    endfunction

endpackage

// File: rtl/jk_mod_counter_stage.sv
// jk_mod_counter_stage: one JK flip-flop bit.
// Synchronous active-high clear; 00 hold, 01 reset, 10 set, 11 toggle.
module jk_mod_counter_stage (
    input  logic clockpulse,
    input  logic clear,
    input  logic jack,
    input  logic kilby,
    output logic out,
    output logic notout
);

    logic q_q;
    logic q_d;

    // JK next-state truth table
    always_comb begin
        q_d = q_q;
        unique case ({jack, kilby})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State register with synchronous clear
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign out    = q_q;
    assign notout = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-N up/down counter of JK stages.
// Steering logic picks J/K per bit for clear, load, wrap or toggle.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             enable,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] loaddata,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] notcount,
    output logic             carry
);

    localparam logic [WIDTH-1:0] TERM_UP =
        WIDTH'(term_value(DIR_UP, MODULUS));
    localparam logic [WIDTH-1:0] TERM_DN =
        WIDTH'(term_value(DIR_DOWN, MODULUS));
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    // Power-of-two modulus wraps by plain binary overflow.
    localparam bit POW2 = (MODULUS == (1 << WIDTH));

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] load_tgt;
    logic [WIDTH-1:0] wrap_tgt;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic             at_term;

    // Terminal detect, clamped load value and ripple toggle enables
    always_comb begin
        logic run;
        at_term  = (updown == DIR_UP) ? (count == TERM_UP)
                                      : (count == TERM_DN);
        wrap_tgt = (updown == DIR_UP) ? TERM_DN : TERM_UP;
        load_tgt = ({1'b0, loaddata} >= MOD_EXT) ? TERM_UP : loaddata;
        toggle   = '0;
        run      = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = run;
            run = run & ((updown == DIR_UP) ? count[i] : notcount[i]);
        end
    end

    // J/K steering: clear > load > wrap/toggle > hold
    always_comb begin
        jk_j = '0;
        jk_k = '0;
        priority case (1'b1)
            clear: begin
                jk_j = '0;
                jk_k = '1;
            end
            load: begin
                jk_j = load_tgt;
                jk_k = ~load_tgt;
            end
            (enable && at_term && !POW2): begin
                jk_j = wrap_tgt;
                jk_k = ~wrap_tgt;
            end
            enable: begin
                jk_j = toggle;
                jk_k = toggle;
            end
            default: begin
                jk_j = '0;
                jk_k = '0;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            jk_mod_counter_stage u_stage (
                .clockpulse(clockpulse),
                .clear     (clear),
                .jack      (jk_j[g]),
                .kilby     (jk_k[g]),
                .out       (count[g]),
                .notout    (notcount[g])
            );
        end
    endgenerate

    assign carry = enable & ~load & ~clear & at_term;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed checks of the decade and
// 3-bit binary configurations of jk_mod_counter.
module tb_jk_mod_counter;
    import jk_mod_counter_pkg::*;

    logic       clk;
    logic       clear, enable, updown, load;
    logic [3:0] loaddata, count, notcount;
    logic       carry;
    logic       c3_clear, c3_enable, c3_updown, c3_load;
    logic [2:0] c3_loaddata, c3_count, c3_notcount;
    logic       c3_carry;

    int n_chk = 0;
    int n_fail = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clockpulse(clk),
        .clear     (clear),
        .enable    (enable),
        .updown    (updown),
        .load      (load),
        .loaddata  (loaddata),
        .count     (count),
        .notcount  (notcount),
        .carry     (carry)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut3 (
        .clockpulse(clk),
        .clear     (c3_clear),
        .enable    (c3_enable),
        .updown    (c3_updown),
        .load      (c3_load),
        .loaddata  (c3_loaddata),
        .count     (c3_count),
        .notcount  (c3_notcount),
        .carry     (c3_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;
        clear = 1'b1; enable = 1'b0; updown = DIR_UP;
        load = 1'b0; loaddata = 4'd0;
        c3_clear = 1'b1; c3_enable = 1'b0; c3_updown = DIR_UP;
        c3_load = 1'b0; c3_loaddata = 3'd0;
        step();
        chk("rst_count", count, 0);
        chk("rst_ncount", notcount, 4'hf);
        clear = 1'b0;
        c3_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_count", count, 0);
            chk("hold_carry", carry, 0);
        end

        enable = 1'b1; updown = DIR_UP;
        exp = 0;
        for (int i = 0; i < 12; i++) begin
            chk("up_carry", carry, (exp == 9) ? 1 : 0);
            step();
            exp = (exp + 1) % 10;
            chk("up_count", count, exp);
            chk("up_ncount", notcount, ~exp & 4'hf);
        end

        load = 1'b1; loaddata = 4'd3; enable = 1'b0;
        step();
        chk("ld3", count, 3);
        load = 1'b0; enable = 1'b1; updown = DIR_DOWN;
        exp = 3;
        for (int i = 0; i < 5; i++) begin
            chk("dn_carry", carry, (exp == 0) ? 1 : 0);
            step();
            exp = (exp == 0) ? 9 : exp - 1;
            chk("dn_count", count, exp);
        end

        enable = 1'b0; load = 1'b1; loaddata = 4'd13;
        step();
        chk("ld_clamp13", count, 9);
        enable = 1'b1; updown = DIR_UP;
        #1;
        chk("carry_ld_mask", carry, 0);
        loaddata = 4'd10;
        step();
        chk("ld_clamp10", count, 9);
        load = 1'b0;
        #1;
        chk("carry_term9", carry, 1);
        load = 1'b1; loaddata = 4'd7; clear = 1'b1;
        #1;
        chk("carry_clr_mask", carry, 0);
        step();
        chk("ld_clr", count, 0);
        load = 1'b0; clear = 1'b0;

        enable = 1'b1; updown = DIR_UP;
        for (int i = 0; i < 5; i++) step();
        chk("up5", count, 5);
        updown = DIR_DOWN;
        step();
        chk("rev4", count, 4);
        step();
        chk("rev3", count, 3);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("en0_count", count, 3);
            chk("en0_carry", carry, 0);
        end
        enable = 1'b1; clear = 1'b1; load = 1'b1; loaddata = 4'd8;
        step();
        chk("clr_mid", count, 0);
        clear = 1'b0; load = 1'b0; enable = 1'b0;

        c3_enable = 1'b1; c3_updown = DIR_UP;
        exp = 0;
        for (int i = 0; i < 9; i++) begin
            chk("b3_carry", c3_carry, (exp == 7) ? 1 : 0);
            step();
            exp = (exp + 1) % 8;
            chk("b3_count", c3_count, exp);
        end
        for (int i = 0; i < 3; i++) step();
        chk("b3_at4", c3_count, 4);
        c3_clear = 1'b1;
        step();
        chk("b3_clr", c3_count, 0);
        chk("b3_nclr", c3_notcount, 3'h7);
        c3_clear = 1'b0; c3_updown = DIR_DOWN;
        #1;
        chk("b3_dn_carry", c3_carry, 1);
        step();
        chk("b3_dn_wrap", c3_count, 7);
        c3_load = 1'b1; c3_loaddata = 3'd5;
        step();
        chk("b3_ld5", c3_count, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
